spi_slv: RTL and testbench
==========================

# spi_slv

SPI peripheral-side (slave) controller, the far end of the bus driven by our SPI master controller. It oversamples `ss`, `sck` and `mosi` in the system clock domain and supports all four CPOL/CPHA modes and frame lengths of 1–16 bits. It drives `miso` and hands each completed received word to the CPU side with a one-cycle valid strobe.

## Interface
- `DATA_W`, 16: width of `tx_data`/`rx_data`; frames use the low `xfer_len+1` bits.
- `SYNC_STAGES`, 2: synchronizer depth on `ss`, `sck`, `mosi`; minimum 2.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: block enable; low forces IDLE.
- `cpol` in 1: SCK idle level.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge.
- `xfer_len` in 4: frame length minus one (bits = `xfer_len+1`).
- `ss` in 1: slave select from the bus, active-low, asynchronous.
- `sck` in 1: bus clock, asynchronous.
- `mosi` in 1: bus data in, asynchronous.
- `miso` out 1: bus data out.
- `miso_oe` out 1: tri-state enable for the `miso` pad buffer.
- `tx_data` in DATA_W: word to transmit; captured at frame start.
- `tx_ack` out 1: one-cycle pulse when `tx_data` is captured.
- `rx_data` out DATA_W: last complete received word, right-justified, upper bits zero.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high in SHIFT and WAIT_SS.

## Operation
- Inputs pass through `SYNC_STAGES` flops. The synchronized `sck` is registered once more for edge detection.
- Leading edge is the first transition away from `cpol`; trailing edge is the return to `cpol`.
- Sample edge: leading if `cpha`=0, trailing if `cpha`=1. Shift edge: the other one.
- States:
  - **IDLE**
    - On synchronized `ss` falling while `en`=1: load `tx_data` into the shift register, pulse `tx_ack`, clear the bit counter, go to SHIFT.
    - With `cpha`=0, `miso` presents the first bit immediately after the load.
  - **SHIFT**
    - Each sample edge: shift in `mosi` and increment the counter.
    - Each shift edge: advance `miso` to the next bit.
    - With `cpha`=1, the first leading edge presents the first bit.
    - When the counter reaches `xfer_len+1`: update `rx_data`, pulse `rx_valid`, go to WAIT_SS.
  - **WAIT_SS**
    - Ignore all `sck` edges and hold `miso`.
    - On `ss` high, go to IDLE.
- Default bit order is MSB-first: bit `xfer_len` goes first, bit 0 last.
- `miso_oe` = `en` and synchronized `ss` low. `miso` is the shift-register output bit.
- Boundary cases:
  - `ss` deasserts in SHIFT: abort to IDLE. No `rx_valid`; `rx_data` is unchanged.
  - `en` low in any state: go to IDLE next cycle, no `rx_valid`.
  - `ss` falling edge while in WAIT_SS or SHIFT: no reload.
  - A shift edge after the last sample is ignored.
  - `cpol`, `cpha` and `xfer_len` must be stable while `busy`=1. Sampling them mid-frame is undefined and is not checked.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ack`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, state IDLE.
- Bus-to-detect latency: `SYNC_STAGES`+1 `clk` cycles from pin transition to the internal edge strobe.
- `tx_ack` and SHIFT entry happen in the same cycle as the `ss`-fall strobe.
- `miso` is valid one cycle later.
- `rx_valid` is asserted in the cycle after the final sample strobe, for exactly 1 cycle, coincident with the new `rx_data`.
- Each SCK half-period must be at least `SYNC_STAGES`+2 `clk` cycles. `ss`-fall-to-first-edge setup must also be at least `SYNC_STAGES`+2 cycles.

## Configuration
- Macro: `SPI_SLV_LSB_FIRST_EN`.
- Defined: bit 0 is transmitted and received first.
- Undefined: MSB-first as described above.
- In both cases `rx_data` is right-justified with the same bit significance as `tx_data`.

## Structure
- Shared package `spi_pkg`:
  - state encodings `S_IDLE`, `S_SHIFT`, `S_WAIT_SS`
  - `SPI_MAX_BITS`=16
  - `SPI_LEN_W`=4
- Sub-module `spi_sync`: N-stage synchronizer plus rise/fall edge detector. Instantiated for `sck` and `ss`; `mosi` uses the synchronizer only.

## Test plan
- Mode 0, `xfer_len`=7, master sends 0xA5, `tx_data`=0x3C → `miso` stream 0x3C MSB-first, `rx_data`=0x00A5, one `rx_valid` pulse.
- Modes 1, 2, 3, `xfer_len`=15, 0xBEEF both directions → `rx_data`=0xBEEF; master receives 0xBEEF.
- `xfer_len`=0, `mosi`=1 → `rx_data`=0x0001; `ss` raised after 4 bits of an 8-bit frame → no `rx_valid`, `rx_data` unchanged.
- Extra 3 SCK pulses after the 8th bit with `ss` still low → single `rx_valid`, `rx_data` unaffected, no second `tx_ack`.
- `rst` asserted mid-frame → all outputs at reset values asynchronously; the next full frame receives correctly.
- With `SPI_SLV_LSB_FIRST_EN`, 8-bit 0x01 → `miso` emits 1 first; `rx_data`=0x0001.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, frame-length
// widths and a small helper for end-of-frame detection.
package spi_pkg;

    localparam int SPI_MAX_BITS = 16;
    localparam int SPI_LEN_W    = 4;
    localparam int SPI_CNT_W    = SPI_LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_WAIT_SS = 2'd2
    } spi_state_t;

    // True when the bits already sampled equal the programmed length minus one,
    // i.e. the sample about to happen is the last of the frame.
    function automatic logic is_last_bit(input logic [SPI_CNT_W-1:0] cnt,
                                         input logic [SPI_LEN_W-1:0] len);
        return cnt == {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_slv_if.sv
// Bundle of configuration, SPI bus and CPU-side signals of the SPI slave.
// The slave modport is the controller's view; master is the bus/CPU side.
interface spi_slv_if #(
    parameter int DATA_W = 16
);
    import spi_pkg::*;

    logic                 en;
    logic                 cpol;
    logic                 cpha;
    logic [SPI_LEN_W-1:0] xfer_len;
    logic                 ss;
    logic                 sck;
    logic                 mosi;
    logic                 miso;
    logic                 miso_oe;
    logic [DATA_W-1:0]    tx_data;
    logic                 tx_ack;
    logic [DATA_W-1:0]    rx_data;
    logic                 rx_valid;
    logic                 busy;

    modport slave (
        input  en, cpol, cpha, xfer_len, ss, sck, mosi, tx_data,
        output miso, miso_oe, tx_ack, rx_data, rx_valid, busy
    );

    modport master (
        output en, cpol, cpha, xfer_len, ss, sck, mosi, tx_data,
        input  miso, miso_oe, tx_ack, rx_data, rx_valid, busy
    );

endinterface

// File: rtl/spi_sync.sv
// N-stage synchronizer followed by one more register used for edge detection.
// level, rise and fall are all aligned: they appear STAGES+1 cycles after the pin.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync_reg [STAGES];
    logic level_reg;
    logic rise_reg;
    logic fall_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= RST_VAL;
                    else     sync_reg[gi] <= d;
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= RST_VAL;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_reg <= RST_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            level_reg <= sync_reg[STAGES-1];
            rise_reg  <= sync_reg[STAGES-1] & ~level_reg;
            fall_reg  <= ~sync_reg[STAGES-1] & level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/spi_slv.sv
// SPI slave controller: oversampled bus inputs, all CPOL/CPHA modes, 1-16 bit frames.
// Optional SPI_SLV_LSB_FIRST_EN switches the bit order to LSB-first (default MSB-first).
module spi_slv
    import spi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    spi_slv_if.slave bus
);
    spi_state_t           state_reg, state_next;
    logic [DATA_W-1:0]    tx_shift_reg, tx_shift_next, tx_shift_adv;
    logic [DATA_W-1:0]    rx_shift_reg, rx_shift_next, rx_in;
    logic [DATA_W-1:0]    rx_data_reg, rx_data_next;
    logic [SPI_CNT_W-1:0] cnt_reg, cnt_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 tx_ack;

    logic sck_level, sck_rise, sck_fall, sck_edge;
    logic lead_stb, trail_stb, sample_stb, shift_stb;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_sync_reg [SYNC_STAGES];
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .d(bus.sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    // ss resets high so the pad stays tri-stated and no false frame start fires.
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d(bus.ss),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_mosi
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) mosi_sync_reg[gi] <= 1'b0;
                    else     mosi_sync_reg[gi] <= bus.mosi;
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) mosi_sync_reg[gi] <= 1'b0;
                    else     mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    // A leading edge leaves the idle level; the post-edge level tells which one it was.
    assign sck_edge   = sck_rise | sck_fall;
    assign lead_stb   = sck_edge & (sck_level != bus.cpol);
    assign trail_stb  = sck_edge & (sck_level == bus.cpol);
    assign sample_stb = bus.cpha ? trail_stb : lead_stb;
    assign shift_stb  = bus.cpha ? lead_stb  : trail_stb;

`ifdef SPI_SLV_LSB_FIRST_EN
    assign bus.miso     = tx_shift_reg[0];
    assign tx_shift_adv = tx_shift_reg >> 1;
    always_comb begin
        rx_in                = rx_shift_reg >> 1;
        rx_in[bus.xfer_len]  = mosi_s;
    end
`else
    assign bus.miso     = tx_shift_reg[bus.xfer_len];
    assign tx_shift_adv = tx_shift_reg << 1;
    assign rx_in        = {rx_shift_reg[DATA_W-2:0], mosi_s};
`endif

    always_comb begin
        state_next    = state_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        cnt_next      = cnt_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        tx_ack        = 1'b0;

        if (!bus.en) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (ss_fall) begin
                        tx_shift_next = bus.tx_data;
                        rx_shift_next = '0;
                        cnt_next      = '0;
                        tx_ack        = 1'b1;
                        state_next    = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ss_rise) begin
                        state_next = S_IDLE;
                    end else begin
                        // The first bit is already on miso after the load, so the
                        // shift edge preceding the first sample (cpha=1) must not advance.
                        if (shift_stb && cnt_reg != '0)
                            tx_shift_next = tx_shift_adv;
                        if (sample_stb) begin
                            rx_shift_next = rx_in;
                            cnt_next      = cnt_reg + 1'b1;
                            if (is_last_bit(cnt_reg, bus.xfer_len)) begin
                                rx_data_next  = rx_in;
                                rx_valid_next = 1'b1;
                                state_next    = S_WAIT_SS;
                            end
                        end
                    end
                end
                S_WAIT_SS: begin
                    if (ss_rise) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            cnt_reg      <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            cnt_reg      <= cnt_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    assign bus.miso_oe  = bus.en & ~ss_level;
    assign bus.tx_ack   = tx_ack;
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_spi_slv.sv
// Randomized scoreboard bench for spi_slv: a bus-level master model drives frames,
// expected words are queued at issue time and popped by an independent rx monitor.
module tb_spi_slv;

    localparam int DATA_W = 16;
    localparam int SYNC   = 2;
    localparam int H      = 6;   // SCK half period in clk cycles
    localparam int SETUP  = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_slv_if #(.DATA_W(DATA_W)) bus ();

    spi_slv #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          ack_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_rx = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Position in the word of the i-th bit on the wire for an n-bit frame.
    function automatic int bidx(input int i, input int n);
`ifdef SPI_SLV_LSB_FIRST_EN
        return i;
`else
        return n - 1 - i;
`endif
    endfunction

    // Monitor: counts tx_ack pulses and checks every rx_valid against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.tx_ack === 1'b1) ack_cnt++;
                if (bus.rx_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_valid_unexpected rx_data=%h expected no word", bus.rx_data);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        chk("rx_data", {16'h0, bus.rx_data}, {16'h0, e});
                        $display("rx word %h", bus.rx_data);
                    end
                end
            end
        end
    end

    // Master frame: sends send_bits of mw, then `extra` surplus SCK pulses.
    task automatic frame(input bit cp, input bit ch, input int n,
                         input logic [15:0] mw, input logic [15:0] tw,
                         input int send_bits, input int extra, input bit raise_ss);
        logic [31:0] m32;
        logic [15:0] mask, mrx;
        int          ack0, k;
        bit          b, complete;
        m32      = (32'h1 << n) - 32'h1;
        mask     = m32[15:0];
        mrx      = '0;
        complete = (send_bits == n);
        bus.cpol     = cp;
        bus.cpha     = ch;
        bus.xfer_len = 4'(n - 1);
        bus.sck      = cp;
        bus.mosi     = 1'b0;
        bus.tx_data  = tw;
        cyc(SETUP);
        ack0 = ack_cnt;
        if (complete) begin
            exp_q.push_back(mw & mask);
            last_rx = mw & mask;
        end
        bus.ss = 1'b0;
        cyc(SETUP);
        bus.tx_data = 16'($urandom);  // word must already be captured
        for (int i = 0; i < send_bits + extra; i++) begin
            k = (i < n) ? bidx(i, n) : 0;
            b = (i < n) ? mw[k] : 1'($urandom);
            if (!ch) begin
                bus.mosi = b;
                cyc(H);
                bus.sck = ~cp;
                if (i < n) mrx[k] = bus.miso;
                cyc(H);
                bus.sck = cp;
            end else begin
                bus.sck  = ~cp;
                bus.mosi = b;
                cyc(H);
                bus.sck = cp;
                if (i < n) mrx[k] = bus.miso;
                cyc(H);
            end
        end
        cyc(H);
        if (complete) begin
            chk("miso_word", {16'h0, mrx}, {16'h0, tw & mask});
            chk("busy_wait_ss", {31'h0, bus.busy}, 32'h1);
            chk("miso_oe_on", {31'h0, bus.miso_oe}, 32'h1);
        end
        if (raise_ss) begin
            bus.ss = 1'b1;
            cyc(SETUP);
            chk("busy_idle", {31'h0, bus.busy}, 32'h0);
            chk("miso_oe_off", {31'h0, bus.miso_oe}, 32'h0);
            chk("tx_ack_count", 32'(ack_cnt - ack0), 32'h1);
            chk("rx_data_final", {16'h0, bus.rx_data}, {16'h0, last_rx});
            chk("rx_pending", 32'(exp_q.size()), 32'h0);
        end
        $display("frame cpol=%0d cpha=%0d bits=%0d/%0d extra=%0d mosi=%h tx=%h master_rx=%h",
                 cp, ch, send_bits, n, extra, mw & mask, tw & mask, mrx);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"},     {31'h0, bus.miso},     32'h0);
        chk({tag, "_miso_oe"},  {31'h0, bus.miso_oe},  32'h0);
        chk({tag, "_tx_ack"},   {31'h0, bus.tx_ack},   32'h0);
        chk({tag, "_rx_data"},  {16'h0, bus.rx_data},  32'h0);
        chk({tag, "_rx_valid"}, {31'h0, bus.rx_valid}, 32'h0);
        chk({tag, "_busy"},     {31'h0, bus.busy},     32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
        bus.xfer_len = 4'd7;
        bus.ss       = 1'b1;
        bus.sck      = 1'b0;
        bus.mosi     = 1'b0;
        bus.tx_data  = '0;
        cyc(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        cyc(SETUP);

        // Mode 0, 8 bits
        frame(1'b0, 1'b0, 8, 16'h00A5, 16'h003C, 8, 0, 1'b1);
        // Modes 1..3, 16 bits
        for (int m = 1; m < 4; m++)
            frame(m[1], m[0], 16, 16'hBEEF, 16'hBEEF, 16, 0, 1'b1);
        // Single-bit frame
        frame(1'b0, 1'b0, 1, 16'h0001, 16'($urandom), 1, 0, 1'b1);
        // Abort after 4 of 8 bits: no word, rx_data held
        frame(1'b0, 1'b0, 8, 16'($urandom), 16'($urandom), 4, 0, 1'b1);
        // Three surplus SCK pulses after the last bit
        frame(1'b0, 1'b0, 8, 16'($urandom), 16'($urandom), 8, 3, 1'b1);
        frame(1'b1, 1'b1, 8, 16'($urandom), 16'($urandom), 8, 3, 1'b1);

        // en dropped mid-frame
        frame(1'b0, 1'b1, 8, 16'($urandom), 16'($urandom), 5, 0, 1'b0);
        chk("busy_before_en_low", {31'h0, bus.busy}, 32'h1);
        bus.en = 1'b0;
        cyc(2);
        chk("busy_en_low", {31'h0, bus.busy}, 32'h0);
        chk("miso_oe_en_low", {31'h0, bus.miso_oe}, 32'h0);
        bus.ss = 1'b1;
        cyc(SETUP);
        bus.en = 1'b1;
        cyc(SETUP);
        chk("rx_data_after_en_low", {16'h0, bus.rx_data}, {16'h0, last_rx});

        // Asynchronous reset mid-frame
        frame(1'b1, 1'b0, 8, 16'($urandom), 16'($urandom), 3, 0, 1'b0);
        chk("busy_before_rst", {31'h0, bus.busy}, 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        bus.ss  = 1'b1;
        bus.sck = bus.cpol;
        cyc(3);
        rst     = 1'b0;
        last_rx = '0;
        cyc(SETUP);
        frame(1'b1, 1'b0, 8, 16'($urandom), 16'($urandom), 8, 0, 1'b1);

        // Bit-order sanity word
        frame(1'b1, 1'b1, 8, 16'h0001, 16'h0001, 8, 0, 1'b1);

        // Random frames
        for (int t = 0; t < 24; t++) begin
            int n;
            n = $urandom_range(1, 16);
            frame(1'($urandom), 1'($urandom), n, 16'($urandom), 16'($urandom), n, 0, 1'b1);
        end

        cyc(SETUP);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
